// File: rtl/bcd_timer_ctrl.sv
// Run/pause/clear/load sequencer for a cascade of BCD decade counters.
// Includes the tick prescaler, digit ripple chain, terminal compare and lap capture.
//
// state | meaning
// IDLE  | stopped after reset, clear or load; prescaler at 0
// RUN   | prescaler advancing, count steps on every tick
// PAUSE | frozen; prescaler keeps its partial progress for resume
// DONE  | count reached limit (WRAP=0); left only via clear or load
module bcd_timer_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int WRAP     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] limit,
  input  logic                lap,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] lap_val,
  output logic                running,
  output logic                done,
  output logic                tick,
  output logic                wrap,
  output logic                load_err
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [CW-1:0] count_nxt, count_inc, load_clean;
  logic          load_bad;
  logic          advance;
  logic          tick_nxt, wrap_nxt, load_err_nxt;
  logic          lap_take;

  // Ripple increment: a digit steps only while every lower digit is 9.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_clean(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd0;
      end
    end
    return r;
  endfunction

  assign count_inc  = bcd_inc(count);
  assign load_clean = bcd_clean(load_val);
  // Any illegal digit is forced to 0, so the cleaned value differs from the raw one.
  assign load_bad   = (load_clean != load_val);
  assign lap_take   = lap && ((state == S_RUN) || (state == S_PAUSE));

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    presc_nxt    = presc;
    advance      = 1'b0;
    tick_nxt     = 1'b0;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;

    if (clear) begin
      state_nxt = S_IDLE;
      count_nxt = '0;
      presc_nxt = '0;
    end else if (load) begin
      state_nxt    = S_IDLE;
      count_nxt    = load_clean;
      presc_nxt    = '0;
      load_err_nxt = load_bad;
    end else if (stop) begin
      if (state == S_RUN) begin
        state_nxt = S_PAUSE;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_RUN;
            presc_nxt = '0;
          end
        end
        S_PAUSE: begin
          if (start) begin
            state_nxt = S_RUN;
          end
        end
        S_RUN:   advance = 1'b1;
        default: ;
      endcase
    end

    if (advance) begin
      if (presc == PS_LAST) begin
        presc_nxt = '0;
        tick_nxt  = 1'b1;
        if (count_inc == limit) begin
          if (WRAP != 0) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end else begin
            count_nxt = count_inc;
            state_nxt = S_DONE;
          end
        end else begin
          count_nxt = count_inc;
        end
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      presc    <= '0;
      count    <= '0;
      lap_val  <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      count    <= count_nxt;
      running  <= (state_nxt == S_RUN);
      done     <= (state_nxt == S_DONE);
      tick     <= tick_nxt;
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
      if (lap_take) begin
        lap_val <= count;
      end
    end
  end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: three configurations driven in lockstep, checked
// every cycle against a decimal-integer reference model through a scoreboard queue.
module tb_bcd_timer_ctrl;

  localparam int N = 3;
  localparam int MODV = 10000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct packed {
    logic [15:0] count;
    logic [15:0] lap_val;
    logic        running;
    logic        done;
    logic        tick;
    logic        wrap;
    logic        load_err;
  } out_t;
  typedef out_t [N-1:0] trio_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] start, stop, clear, load, lap;
  logic [N-1:0][15:0] load_val, limit;
  logic [N-1:0][15:0] count, lap_val;
  logic [N-1:0] running, done, tick, wrap, load_err;

  int n_chk = 0;
  int n_pass = 0;
  trio_t exp_q[$];

  int m_st[N], m_cnt[N], m_ps[N], m_lap[N];

  always #5 clk = ~clk;

  // Instance 0: PRESCALE=2 stop-at-limit, 1: PRESCALE=4 stop-at-limit, 2: PRESCALE=1 modulo.
  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      bcd_timer_ctrl #(
        .DIGITS(4),
        .PRESCALE(g == 0 ? 2 : (g == 1 ? 4 : 1)),
        .WRAP(g == 2 ? 1 : 0)
      ) u_dut (
        .clk(clk), .rst(rst), .start(start[g]), .stop(stop[g]), .clear(clear[g]),
        .load(load[g]), .load_val(load_val[g]), .limit(limit[g]), .lap(lap[g]),
        .count(count[g]), .lap_val(lap_val[g]), .running(running[g]), .done(done[g]),
        .tick(tick[g]), .wrap(wrap[g]), .load_err(load_err[g])
      );
    end
  endgenerate

  function automatic int ps_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 4 : 1);
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    int v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: count kept as a plain decimal integer.
  task automatic model_step(input int g, output out_t o);
    logic tk, wr, le;
    logic [3:0] d;
    int lv, nv;
    tk = 1'b0; wr = 1'b0; le = 1'b0;
    if (rst) begin
      m_st[g] = M_IDLE; m_cnt[g] = 0; m_ps[g] = 0; m_lap[g] = 0;
    end else begin
      if (lap[g] && (m_st[g] == M_RUN || m_st[g] == M_PAUSE)) m_lap[g] = m_cnt[g];
      if (clear[g]) begin
        m_st[g] = M_IDLE; m_cnt[g] = 0; m_ps[g] = 0;
      end else if (load[g]) begin
        lv = 0;
        for (int i = 3; i >= 0; i--) begin
          d = load_val[g][i*4 +: 4];
          if (d > 4'd9) begin
            le = 1'b1;
            d = 4'd0;
          end
          lv = lv * 10 + int'(d);
        end
        m_st[g] = M_IDLE; m_cnt[g] = lv; m_ps[g] = 0;
      end else if (stop[g]) begin
        if (m_st[g] == M_RUN) m_st[g] = M_PAUSE;
      end else if (start[g] && m_st[g] == M_IDLE) begin
        m_st[g] = M_RUN; m_ps[g] = 0;
      end else if (start[g] && m_st[g] == M_PAUSE) begin
        m_st[g] = M_RUN;
      end else if (m_st[g] == M_RUN) begin
        m_ps[g]++;
        if (m_ps[g] == ps_of(g)) begin
          m_ps[g] = 0;
          tk = 1'b1;
          nv = (m_cnt[g] + 1) % MODV;
          if (nv == bcd2int(limit[g])) begin
            if (g == 2) begin
              m_cnt[g] = 0;
              wr = 1'b1;
            end else begin
              m_cnt[g] = nv;
              m_st[g] = M_DONE;
            end
          end else begin
            m_cnt[g] = nv;
          end
        end
      end
    end
    o.count    = int2bcd(m_cnt[g]);
    o.lap_val  = int2bcd(m_lap[g]);
    o.running  = (m_st[g] == M_RUN);
    o.done     = (m_st[g] == M_DONE);
    o.tick     = tk;
    o.wrap     = wr;
    o.load_err = le;
  endtask

  // Inputs are stable from one negedge to the next; expectation is pushed before the edge.
  task automatic step();
    trio_t e;
    out_t o;
    for (int g = 0; g < N; g++) begin
      model_step(g, o);
      e[g] = o;
    end
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b0; start = '0; stop = '0; clear = '0; load = '0; lap = '0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin : monitor
    trio_t e;
    out_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int g = 0; g < N; g++) begin
          a.count = count[g]; a.lap_val = lap_val[g]; a.running = running[g];
          a.done = done[g]; a.tick = tick[g]; a.wrap = wrap[g]; a.load_err = load_err[g];
          chk($sformatf("out%0d", g), 64'(a), 64'(e[g]));
        end
      end
    end
  end

  initial begin : stim
    int seq_c[6];
    logic seq_w[6];
    rst = 1'b1; start = '0; stop = '0; clear = '0; load = '0; lap = '0;
    load_val = '0;
    for (int g = 0; g < N; g++) limit[g] = 16'h9999;
    @(negedge clk);

    rst = 1'b1; step();
    rst = 1'b1; step();
    chk("reset_count", 64'(count[0]), 64'h0);
    chk("reset_flags", 64'({running, done, tick, wrap, load_err}), 64'h0);

    // Preset and carry into the hundreds digit.
    load_val[0] = 16'h0098; load[0] = 1'b1; step();
    chk("t1_load", 64'(count[0]), 64'h0098);
    start[0] = 1'b1; step();
    run(2);
    chk("t1_99", 64'(count[0]), 64'h0099);
    chk("t1_tick99", 64'(tick[0]), 64'h1);
    run(2);
    chk("t1_100", 64'(count[0]), 64'h0100);
    chk("t1_tick100", 64'(tick[0]), 64'h1);

    // Terminal stop at 12.
    clear[0] = 1'b1; limit[0] = 16'h0012; step();
    start[0] = 1'b1; step();
    run(24);
    chk("t2_cnt", 64'(count[0]), 64'h0012);
    chk("t2_done", 64'({done[0], running[0]}), 64'b10);
    start[0] = 1'b1; step();
    run(3);
    chk("t2_hold", 64'({count[0], done[0]}), 64'({16'h0012, 1'b1}));
    clear[0] = 1'b1; step();
    chk("t2_clear", 64'({count[0], done[0]}), 64'h0);

    // Modulo 5 with a single wrap pulse.
    seq_c = '{1, 2, 3, 4, 0, 1};
    seq_w = '{0, 0, 0, 0, 1, 0};
    limit[2] = 16'h0005; start[2] = 1'b1; step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t3_seq%0d", i), 64'({count[2], wrap[2]}), 64'({int2bcd(seq_c[i]), seq_w[i]}));
    end

    // Pause two cycles into a tick period, resume finishes the remaining two.
    start[1] = 1'b1; step();
    run(4);
    chk("t4_first", 64'(count[1]), 64'h0001);
    run(2);
    stop[1] = 1'b1; step();
    run(10);
    chk("t4_frozen", 64'({count[1], running[1]}), 64'({16'h0001, 1'b0}));
    start[1] = 1'b1; step();
    step();
    chk("t4_pre", 64'(count[1]), 64'h0001);
    step();
    chk("t4_resume", 64'({count[1], tick[1]}), 64'({16'h0002, 1'b1}));

    // Command collisions.
    start[0] = 1'b1; stop[0] = 1'b1; step();
    chk("t5_idle", 64'(running[0]), 64'h0);
    load_val[0] = 16'h0055; clear[0] = 1'b1; load[0] = 1'b1; step();
    chk("t5_clrld", 64'(count[0]), 64'h0);
    load_val[0] = 16'h0009; load[0] = 1'b1; step();
    start[0] = 1'b1; step();
    step();
    lap[0] = 1'b1; step();
    chk("t5_lap", 64'({lap_val[0], count[0]}), 64'({16'h0009, 16'h0010}));

    // Bad digit load, then reset mid-run.
    load_val[0] = 16'h00A3; load[0] = 1'b1; step();
    chk("t6_bad", 64'({count[0], load_err[0]}), 64'({16'h0003, 1'b1}));
    step();
    chk("t6_errpulse", 64'(load_err[0]), 64'h0);
    load_val[0] = 16'h0041; load[0] = 1'b1; step();
    start[0] = 1'b1; step();
    run(2);
    chk("t6_42", 64'(count[0]), 64'h0042);
    rst = 1'b1; step();
    chk("t6_rst", 64'({count[0], running[0]}), 64'h0);

    // Randomized commands on all three instances.
    for (int k = 0; k < 3000; k++) begin
      for (int g = 0; g < N; g++) begin
        start[g] = ($urandom_range(0, 99) < 20);
        stop[g]  = ($urandom_range(0, 99) < 5);
        clear[g] = ($urandom_range(0, 99) < 2);
        load[g]  = ($urandom_range(0, 99) < 3);
        lap[g]   = ($urandom_range(0, 99) < 10);
        load_val[g] = ($urandom_range(0, 1) == 0) ? int2bcd($urandom_range(0, 9999))
                                                   : 16'($urandom);
        if ($urandom_range(0, 99) < 2) limit[g] = int2bcd($urandom_range(0, 40));
      end
      rst = ($urandom_range(0, 999) < 3);
      step();
    end

    @(posedge clk);
    #2;
    chk("queue_drain", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
- Sequencing controller for a cascade of decade (0-9) BCD digit counters.
- Provides the run/pause/clear/load control plane, a clock prescaler that generates count ticks, and the ripple-enable chain between digits.
- Provides terminal-count detection against a programmable BCD limit, plus a lap-capture register.
- Sits between the front-panel/command logic and the display/decoder path of the timer subsystem.

Parameters:
- DIGITS, 4: number of BCD digits; count width is 4*DIGITS.
- PRESCALE, 1000: clk cycles per count tick; legal range >=1.
- WRAP, 0:
  - 0: stop in DONE when the count reaches limit.
  - 1: count modulo limit and pulse wrap.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- start  input  1  level-sampled command: enter or resume RUN
- stop  input  1  command: RUN -> PAUSE
- clear  input  1  command: count := 0, go to IDLE
- load  input  1  command: count := load_val, go to IDLE
- load_val  input  4*DIGITS  BCD preset, digit 0 in bits [3:0]
- limit  input  4*DIGITS  BCD terminal value, sampled every cycle
- lap  input  1  capture the current count into lap_val
- count  output  4*DIGITS  current BCD count
- lap_val  output  4*DIGITS  last captured count
- running  output  1  high in RUN
- done  output  1  high in DONE
- tick  output  1  one-cycle pulse on each count advance
- wrap  output  1  one-cycle pulse when the count wraps to 0
- load_err  output  1  one-cycle pulse when load_val contains a digit >9

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; count=0; lap_val=0; prescaler=0.
  - running, done, tick, wrap and load_err all 0.
  - rst overrides every command in the same cycle.
- Registered outputs: all outputs are registered. Effects of a command appear the cycle after it is sampled.
- State machine: states are IDLE, RUN, PAUSE, DONE.
- Command priority per cycle: clear > load > stop > start.
  - clear: count=0, prescaler=0, state=IDLE. Legal in any state.
  - load:
    - count=load_val, prescaler=0, state=IDLE. Legal in any state.
    - Any digit >9 loads as 0 and load_err pulses for one cycle.
  - stop: RUN -> PAUSE; the prescaler holds its value. In other states stop is ignored.
  - start:
    - IDLE -> RUN with prescaler=0.
    - PAUSE -> RUN, resuming from the held prescaler value.
    - Ignored in RUN and in DONE.
    - DONE is left only via clear or load.
  - start and stop in the same cycle: stop wins. From PAUSE or IDLE the state is unchanged.
- Prescaler:
  - Advances only in RUN and counts 0..PRESCALE-1.
  - At PRESCALE-1 it returns to 0 and a tick event occurs.
  - PRESCALE=1 gives a tick event every RUN cycle.
  - tick is asserted in the cycle count shows the new value.
- Count advance on a tick event:
  - Digit 0 increments.
  - Digit i increments only when digits 0..i-1 are all 9.
  - Any digit at 9 that increments becomes 0.
  - All-9s rolls over to all-0s with no wrap pulse; this occurs only if limit is unreachable.
- Terminal check: compare next_count against limit; the compare uses the current limit value.
  - WRAP=0 and next_count==limit: count=limit, state=DONE, done=1. running drops in the same cycle.
  - WRAP=1 and next_count==limit: count=0, wrap pulses for one cycle, state stays RUN.
  - limit==0 with WRAP=0: DONE on the tick that rolls all-9s to 0.
  - limit==0 with WRAP=1: same rollover, with a wrap pulse.
  - If limit is changed below the current count, counting continues to the all-9s rollover. There is no greater-than compare.
- Lap:
  - In RUN or PAUSE, lap captures count into lap_val.
  - If a tick event occurs in the same cycle, the pre-tick value is captured.
  - lap is ignored in IDLE and DONE.
- clear or load mid-RUN discards any pending prescaler progress. No tick is issued in that cycle.

Test Plan:
1. Reset/preset: PRESCALE=2, DIGITS=4, rst pulse, then load with load_val=0x0098, then start.
   - After reset: count=0x0000, all flags 0.
   - count becomes 0x0098, then 0x0099 two cycles after RUN entry.
   - Then 0x0100, with a tick pulse on each advance.
2. Terminal stop: WRAP=0, limit=0x0012, start from 0.
   - count steps 0x0000..0x0012.
   - On reaching 0x0012: done=1, running=0.
   - A further start has no effect; clear gives count=0x0000 and done=0.
3. Modulo wrap: WRAP=1, limit=0x0005.
   - Sequence is 0,1,2,3,4,0,1 with a single wrap pulse coincident with the 4->0 transition.
4. Pause and resume: PRESCALE=4; assert stop two cycles into a tick period, hold 10 cycles, then start.
   - count is frozen during the hold.
   - The next tick arrives 2 cycles after resume, not 4.
5. Command collisions:
   - start+stop in IDLE: stays IDLE.
   - clear+load together: count=0.
   - lap coincident with the 0x0009->0x0010 tick: lap_val=0x0009, count=0x0010.
6. Bad load and reset mid-run:
   - load_val=0x00A3: count=0x0003 and load_err pulses once.
   - rst during RUN at 0x0042: count=0x0000, IDLE, running=0 in the next cycle.
